axi_exclusive_mem_slave: RTL and testbench
==========================================

Name: axi_exclusive_mem_slave

Overview:
- Single-port, word-addressed AXI4 slave memory that sits directly downstream of the core's AXI master memory sub-unit and consumes its single-beat read/write transactions.
- Implements AXI exclusive-access semantics (arlock/awlock, EXOKAY) with a one-entry reservation monitor, so LR/SC and read-modify-write AMOs issued by the core complete or retry correctly.
- Used as on-chip data RAM in simulation and FPGA builds.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h8000_0000: byte base address, aligned to DEPTH_WORDS*4.
- ID_W, 6: width of awid/arid/bid/rid.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- awvalid in 1, awready out 1, awaddr in 32, awlen in 8, awburst in 2, awid in ID_W, awlock in 1: write address channel
- wvalid in 1, wready out 1, wdata in 32, wstrb in 4: write data channel (wlast ignored)
- bvalid out 1, bready in 1, bresp out 2, bid out ID_W: write response channel
- arvalid in 1, arready out 1, araddr in 32, arlen in 8, arburst in 2, arid in ID_W, arlock in 1: read address channel
- rvalid out 1, rready in 1, rdata out 32, rresp out 2, rid out ID_W, rlast out 1: read data channel
- excl_valid out 1: monitor armed (debug/verification visibility)

Behaviour:
- Reset (async assert, sync deassert by user):
  - state=IDLE; all ready/valid outputs 0; bresp/rresp/rdata 0; monitor cleared.
  - Memory contents are not reset.
- One transaction is in service at a time. FSM states: IDLE, WR_COLLECT, RD_ACCESS, RD_RESP, WR_RESP.
- IDLE:
  - awready=wready=arready=1.
  - If awvalid or wvalid is set in a cycle, it wins over arvalid (write priority).
  - aw and w may arrive in the same cycle or separately. Each captured channel drops its ready.
  - Once both aw and w are held, go to WR_RESP. If only one is held, go to WR_COLLECT.
  - arvalid with no aw/w activity: capture ar, go to RD_ACCESS.
- WR_COLLECT: the missing channel's ready=1; on handshake go to WR_RESP. An ar handshake is never accepted in this state.
- Write decision, evaluated on entry to WR_RESP (the memory write happens in that same edge):
  - Address out of range or not 4-byte aligned: bresp=2'b11 (DECERR), no write.
  - awlen!=0 or awburst not in {0,1}: bresp=2'b10 (SLVERR), no write.
  - awlock=1, monitor valid, and monitor word address equals the write address: write the bytes enabled by wstrb; bresp=2'b01 (EXOKAY); clear the monitor.
  - awlock=1 with no match: no write; bresp=2'b00 (OKAY = exclusive fail); monitor unchanged.
  - awlock=0: write the bytes enabled by wstrb; bresp=2'b00. If the monitor address matches, clear the monitor.
- WR_RESP: bvalid=1, bid=captured awid. On bready go to IDLE.
- RD_ACCESS: one cycle of synchronous RAM read.
  - Same range and len/burst checks as writes. Errors give rdata=0 with 2'b11/2'b10.
  - arlock=1 and no error: arm the monitor with the word address (overwrites any prior entry); rresp=2'b01.
  - Otherwise rresp=2'b00.
- RD_RESP: rvalid=1, rlast=1, rid=captured arid; rdata and rresp held stable while rvalid is high. On rready go to IDLE.
- Latency: read ar handshake to rvalid = 2 cycles; last of aw/w handshake to bvalid = 1 cycle.
- Back-to-back transactions need one IDLE cycle between them; throughput is 1 per 3 cycles for reads and 1 per 2 cycles for writes.
- Word index = (addr - BASE_ADDR) >> 2, using log2(DEPTH_WORDS) bits. The range check uses the full 32-bit subtraction, so addresses below BASE_ADDR are out of range.
- Reset asserted mid-transaction: any pending response is abandoned, the monitor is cleared, and the FSM returns to IDLE. A write that had not reached WR_RESP is not performed.

Decomposition:
- Shared package (memory types package) holds:
  - AXI response constants: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The FSM state enum.
  - The monitor struct {valid, word_addr}.
- One sub-module, byte_enable_ram: a DEPTH_WORDS x 32 synchronous RAM with a 4-bit byte write enable and 1-cycle read.

Test Plan:
- Plain write then read: write 0xDEADBEEF, wstrb=4'hF, to BASE+0x10, then read BASE+0x10 -> bresp=00; rdata=0xDEADBEEF, rresp=00, rvalid exactly 2 cycles after the ar handshake.
- Partial strobe: word preloaded with 0x11223344, write wdata=0xAABBCCDD with wstrb=4'b0101 -> a later read returns 0x11BB33DD.
- LR/SC success: exclusive read of BASE+0x20 (rresp=01, excl_valid=1), then exclusive write 0x5 to BASE+0x20 -> bresp=01, memory holds 5, excl_valid=0.
- SC failure after an intervening store: exclusive read of A, plain write to A, exclusive write 0x7 to A -> bresp=00, memory holds the plain-write value. Also: exclusive write with no prior exclusive read -> bresp=00.
- Channel ordering and backpressure: wvalid 3 cycles before awvalid, bready held low 4 cycles -> write completes once; bvalid and bresp stay stable until bready. Simultaneous awvalid/wvalid/arvalid -> write served first, read second.
- Errors and reset: read of BASE+DEPTH_WORDS*4 -> rresp=11, rdata=0; arlen=3 -> rresp=10. Reset asserted while in RD_RESP -> rvalid=0 immediately and excl_valid=0.

Source files
------------

// File: rtl/axi_exclusive_mem_slave_pkg.sv
// Shared types and constants for the exclusive-access AXI slave memory.
package axi_exclusive_mem_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWrCollect,
        StRdAccess,
        StRdResp,
        StWrResp
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [29:0] word_addr;
    } excl_mon_t;

    // offset is addr - base; base is span-aligned, so offset[1:0] equals addr[1:0].
    function automatic logic [1:0] access_check(input logic [31:0] offset,
                                                input logic [31:0] span,
                                                input logic [7:0]  len,
                                                input logic [1:0]  burst);
        if (offset >= span || offset[1:0] != 2'b00) return RESP_DECERR;
        if (len != 8'd0 || burst[1]) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_exclusive_mem_slave_if.sv
// AXI4 channel bundle between the core's memory master and the slave RAM.
interface axi_exclusive_mem_slave_if #(
    parameter int unsigned ID_W = 6
);
    logic            awvalid, awready, awlock;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [1:0]      awburst;
    logic [ID_W-1:0] awid;

    logic            wvalid, wready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;

    logic            bvalid, bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    logic            arvalid, arready, arlock;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [1:0]      arburst;
    logic [ID_W-1:0] arid;

    logic            rvalid, rready, rlast;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic [ID_W-1:0] rid;

    modport master (
        output awvalid, awaddr, awlen, awburst, awid, awlock,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arlen, arburst, arid, arlock,
        output rready,
        input  awready, wready, bvalid, bresp, bid, arready,
        input  rvalid, rdata, rresp, rid, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen, awburst, awid, awlock,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arlen, arburst, arid, arlock,
        input  rready,
        output awready, wready, bvalid, bresp, bid, arready,
        output rvalid, rdata, rresp, rid, rlast
    );
endinterface

// File: rtl/axi_exclusive_mem_slave_byte_enable_ram.sv
// Word-wide synchronous RAM with per-byte write enables and a registered read port.
module axi_exclusive_mem_slave_byte_enable_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic             re,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/axi_exclusive_mem_slave.sv
// AXI4 single-beat slave RAM with a one-entry exclusive-access reservation monitor.
// One transaction in service at a time; write channels take priority over reads.
module axi_exclusive_mem_slave
    import axi_exclusive_mem_slave_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned ID_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    axi_exclusive_mem_slave_if.slave bus,
    output logic                     excl_valid
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

    state_e          state_q, state_d;
    logic            aw_fire, w_fire, ar_fire, wr_enter;
    logic            aw_rdy, w_rdy, ar_rdy;
    logic            aw_held_q, w_held_q, awlock_q, arlock_q;
    logic [31:0]     awaddr_q, wdata_q, araddr_q, rdata_q;
    logic [7:0]      awlen_q, arlen_q;
    logic [1:0]      awburst_q, arburst_q, bresp_q, rresp_q;
    logic [3:0]      wstrb_q;
    logic [ID_W-1:0] awid_q, arid_q;
    excl_mon_t       mon_q, mon_d;

    logic [31:0]     eff_awaddr, eff_wdata;
    logic [7:0]      eff_awlen;
    logic [1:0]      eff_awburst, wr_chk, wr_resp, rd_chk, rd_resp;
    logic [3:0]      eff_wstrb;
    logic            eff_awlock, wr_hit, wr_allow, wr_clear, ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0]     ram_rdata;

    always_comb begin
        state_d = state_q;
        aw_rdy  = 1'b0;
        w_rdy   = 1'b0;
        ar_rdy  = 1'b0;
        unique case (state_q)
            StIdle: begin
                aw_rdy = 1'b1;
                w_rdy  = 1'b1;
                // Hold off the read channel whenever a write channel is active.
                ar_rdy = !bus.awvalid && !bus.wvalid;
            end
            StWrCollect: begin
                aw_rdy = !aw_held_q;
                w_rdy  = !w_held_q;
            end
            default: ;
        endcase
        aw_fire = bus.awvalid && aw_rdy;
        w_fire  = bus.wvalid && w_rdy;
        ar_fire = bus.arvalid && ar_rdy;
        unique case (state_q)
            StIdle: begin
                if (aw_fire && w_fire) state_d = StWrResp;
                else if (aw_fire || w_fire) state_d = StWrCollect;
                else if (ar_fire) state_d = StRdAccess;
            end
            StWrCollect: if (aw_fire || w_fire) state_d = StWrResp;
            StRdAccess:  state_d = StRdResp;
            StRdResp:    if (bus.rready) state_d = StIdle;
            StWrResp:    if (bus.bready) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
        wr_enter    = (state_d == StWrResp) && (state_q != StWrResp);
        bus.awready = aw_rdy && rst;
        bus.wready  = w_rdy && rst;
        bus.arready = ar_rdy && rst;
    end

    // Write decision uses whichever of held or just-arriving channel values is current.
    always_comb begin
        eff_awaddr  = aw_fire ? bus.awaddr : awaddr_q;
        eff_awlen   = aw_fire ? bus.awlen : awlen_q;
        eff_awburst = aw_fire ? bus.awburst : awburst_q;
        eff_awlock  = aw_fire ? bus.awlock : awlock_q;
        eff_wdata   = w_fire ? bus.wdata : wdata_q;
        eff_wstrb   = w_fire ? bus.wstrb : wstrb_q;
        wr_chk      = access_check(eff_awaddr - BASE_ADDR, SPAN, eff_awlen, eff_awburst);
        wr_hit      = mon_q.valid && (mon_q.word_addr == eff_awaddr[31:2]);
        wr_resp     = wr_chk;
        wr_allow    = 1'b0;
        wr_clear    = 1'b0;
        if (wr_chk == RESP_OKAY) begin
            wr_allow = !eff_awlock || wr_hit;
            wr_clear = wr_hit;
            wr_resp  = (eff_awlock && wr_hit) ? RESP_EXOKAY : RESP_OKAY;
        end

        rd_chk  = access_check(araddr_q - BASE_ADDR, SPAN, arlen_q, arburst_q);
        rd_resp = (rd_chk != RESP_OKAY) ? rd_chk : (arlock_q ? RESP_EXOKAY : RESP_OKAY);

        mon_d = mon_q;
        if (wr_enter && wr_clear) mon_d.valid = 1'b0;
        if (state_q == StRdAccess && rd_chk == RESP_OKAY && arlock_q) begin
            mon_d = '{valid: 1'b1, word_addr: araddr_q[31:2]};
        end

        // BASE_ADDR is span-aligned, so the low address bits are the word index.
        ram_we   = wr_enter && wr_allow;
        ram_addr = ram_we ? eff_awaddr[IDX_W+1:2] : bus.araddr[IDX_W+1:2];
    end

    axi_exclusive_mem_slave_byte_enable_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W(IDX_W)
    ) u_ram (
        .clk(clk),
        .we(ram_we),
        .be(eff_wstrb),
        .re(ar_fire),
        .addr(ram_addr),
        .wdata(eff_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awburst_q <= '0;
            awid_q    <= '0;
            awlock_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arburst_q <= '0;
            arid_q    <= '0;
            arlock_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            mon_q     <= '0;
        end else begin
            state_q <= state_d;
            mon_q   <= mon_d;
            if (wr_enter) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bresp_q   <= wr_resp;
            end else begin
                if (aw_fire) aw_held_q <= 1'b1;
                if (w_fire) w_held_q <= 1'b1;
            end
            if (aw_fire) begin
                awaddr_q  <= bus.awaddr;
                awlen_q   <= bus.awlen;
                awburst_q <= bus.awburst;
                awid_q    <= bus.awid;
                awlock_q  <= bus.awlock;
            end
            if (w_fire) begin
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end
            if (ar_fire) begin
                araddr_q  <= bus.araddr;
                arlen_q   <= bus.arlen;
                arburst_q <= bus.arburst;
                arid_q    <= bus.arid;
                arlock_q  <= bus.arlock;
            end
            if (state_q == StRdAccess) begin
                rresp_q <= rd_resp;
                rdata_q <= (rd_chk == RESP_OKAY) ? ram_rdata : 32'h0;
            end
        end
    end

    assign bus.bvalid = (state_q == StWrResp);
    assign bus.bresp  = bresp_q;
    assign bus.bid    = awid_q;
    assign bus.rvalid = (state_q == StRdResp);
    assign bus.rlast  = (state_q == StRdResp);
    assign bus.rdata  = rdata_q;
    assign bus.rresp  = rresp_q;
    assign bus.rid    = arid_q;
    assign excl_valid = mon_q.valid;
endmodule

// File: tb/tb_axi_exclusive_mem_slave.sv
// Randomized self-checking bench for axi_exclusive_mem_slave against a transaction-level model.
module tb_axi_exclusive_mem_slave;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic excl_valid;
    int   errors = 0;
    int   checks = 0;

    axi_exclusive_mem_slave_if #(.ID_W(6)) bus ();

    axi_exclusive_mem_slave #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR(BASE),
        .ID_W(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .excl_valid(excl_valid)
    );

    always #5 clk = ~clk;

    // Reference state: word contents (only words with fully known value) and the reservation.
    logic [31:0] ref_mem [int];
    bit          ref_mon_valid = 0;
    logic [31:0] ref_mon_addr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_resp(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [1:0] burst);
        if (addr < BASE || addr >= BASE + SPAN || addr % 4 != 0) return 2'b11;
        if (len != 0 || burst > 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic lock, input logic [7:0] len,
                             input logic [1:0] burst, output logic [1:0] resp);
        int          idx;
        bit          hit;
        logic [31:0] w;
        resp = ref_resp(addr, len, burst);
        if (resp != 2'b00) return;
        hit = ref_mon_valid && ref_mon_addr == addr;
        if (lock && !hit) return;
        idx = int'((addr - BASE) / 4);
        if (ref_mem.exists(idx) || strb == 4'hF) begin
            w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
            for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
            ref_mem[idx] = w;
        end
        if (lock) resp = 2'b01;
        if (hit) ref_mon_valid = 0;
    endtask

    task automatic ref_read(input logic [31:0] addr, input logic lock, input logic [7:0] len,
                            input logic [1:0] burst, output logic [1:0] resp,
                            output logic [31:0] data, output bit known);
        int idx;
        resp  = ref_resp(addr, len, burst);
        data  = 32'h0;
        known = 1;
        if (resp != 2'b00) return;
        idx   = int'((addr - BASE) / 4);
        known = ref_mem.exists(idx);
        if (known) data = ref_mem[idx];
        if (lock) begin
            ref_mon_valid = 1;
            ref_mon_addr  = addr;
            resp          = 2'b01;
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic lock, input logic [7:0] len,
                             input logic [1:0] burst, input int w_lead, input int b_delay,
                             output logic [1:0] resp);
        logic [1:0] exp_resp;
        logic [5:0] id;
        bit         aw_done, w_done, aw_on, aw_hs, w_hs;
        int         n;
        id = 6'($urandom);
        ref_write(addr, data, strb, lock, len, burst, exp_resp);
        @(negedge clk);
        bus.wvalid  = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awburst = burst;
        bus.awid    = id;
        bus.awlock  = lock;
        aw_on       = (w_lead == 0);
        bus.awvalid = aw_on;
        aw_done     = 0;
        w_done      = 0;
        n           = 0;
        while (!(aw_done && w_done) && n < 50) begin
            #1;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(negedge clk);
            n++;
            if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (w_hs) begin bus.wvalid = 1'b0; w_done = 1; end
            if (!aw_on && n >= w_lead) begin bus.awvalid = 1'b1; aw_on = 1; end
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("wr_handshake", 32'(aw_done && w_done), 1);
        check("bvalid_latency", 32'(bus.bvalid), 1);
        for (int i = 0; i < b_delay; i++) begin
            check("bresp_hold", {bus.bvalid, bus.bresp}, {1'b1, exp_resp});
            @(negedge clk);
        end
        resp = bus.bresp;
        check("bresp", bus.bresp, exp_resp);
        check("bid", bus.bid, id);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("bvalid_clear", 32'(bus.bvalid), 0);
        check("excl_valid_wr", 32'(excl_valid), 32'(ref_mon_valid));
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic lock, input logic [7:0] len,
                            input logic [1:0] burst, input bit rst_in_resp,
                            output logic [31:0] data, output logic [1:0] resp);
        logic [5:0]  id;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bit          known, hs;
        int          n, lat;
        id = 6'($urandom);
        @(negedge clk);
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arburst = burst;
        bus.arid    = id;
        bus.arlock  = lock;
        hs = 0;
        n  = 0;
        while (!hs && n < 50) begin
            #1;
            hs = bus.arvalid && bus.arready;
            @(negedge clk);
            n++;
        end
        bus.arvalid = 1'b0;
        check("ar_handshake", 32'(hs), 1);
        lat = 1;
        while (!bus.rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("r_latency", lat, 2);
        ref_read(addr, lock, len, burst, exp_resp, exp_data, known);
        data = bus.rdata;
        resp = bus.rresp;
        if (known) check("rdata", bus.rdata, exp_data);
        check("rresp", bus.rresp, exp_resp);
        check("rid", bus.rid, id);
        check("rlast", 32'(bus.rlast), 1);
        check("excl_valid_rd", 32'(excl_valid), 32'(ref_mon_valid));
        @(negedge clk);
        check("rdata_hold", bus.rdata, data);
        check("rvalid_hold", {bus.rvalid, bus.rresp}, {1'b1, resp});
        if (rst_in_resp) begin
            rst = 1'b0;
            #1;
            check("rst_rvalid", 32'(bus.rvalid), 0);
            check("rst_excl_valid", 32'(excl_valid), 0);
            check("rst_arready", 32'(bus.arready), 0);
            ref_mon_valid = 0;
            @(negedge clk);
            rst = 1'b1;
        end else begin
            bus.rready = 1'b1;
            @(negedge clk);
            bus.rready = 1'b0;
            check("rvalid_clear", 32'(bus.rvalid), 0);
        end
    endtask

    initial begin
        logic [31:0] d, d2, addr;
        logic [1:0]  r, r2;
        bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awburst = 0;
        bus.awid = 0; bus.awlock = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0;
        bus.arburst = 0; bus.arid = 0; bus.arlock = 0; bus.rready = 0;
        repeat (2) @(negedge clk);
        check("rst_awready", 32'(bus.awready), 0);
        check("rst_wready", 32'(bus.wready), 0);
        check("rst_arready0", 32'(bus.arready), 0);
        check("rst_bvalid", 32'(bus.bvalid), 0);
        check("rst_rvalid0", 32'(bus.rvalid), 0);
        check("rst_bresp", bus.bresp, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_excl", 32'(excl_valid), 0);
        rst = 1'b1;

        // Plain write then read.
        axi_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2'd1, 0, 0, r);
        check("plain_bresp", r, 2'b00);
        axi_read(BASE + 32'h10, 0, 0, 2'd1, 0, d, r);
        check("plain_rdata", d, 32'hDEADBEEF);

        // Partial strobe merge.
        axi_write(BASE + 32'h30, 32'h11223344, 4'hF, 0, 0, 2'd1, 0, 0, r);
        axi_write(BASE + 32'h30, 32'hAABBCCDD, 4'b0101, 0, 0, 2'd1, 0, 0, r);
        axi_read(BASE + 32'h30, 0, 0, 2'd1, 0, d, r);
        check("strobe_rdata", d, 32'h11BB33DD);

        // LR/SC success.
        axi_read(BASE + 32'h20, 1, 0, 2'd1, 0, d, r);
        check("lr_rresp", r, 2'b01);
        check("lr_excl", 32'(excl_valid), 1);
        axi_write(BASE + 32'h20, 32'h5, 4'hF, 1, 0, 2'd1, 0, 0, r);
        check("sc_ok_bresp", r, 2'b01);
        check("sc_ok_excl", 32'(excl_valid), 0);
        axi_read(BASE + 32'h20, 0, 0, 2'd1, 0, d, r);
        check("sc_ok_rdata", d, 32'h5);

        // SC failure after intervening store, then SC with no reservation.
        axi_read(BASE + 32'h24, 1, 0, 2'd0, 0, d, r);
        axi_write(BASE + 32'h24, 32'h1234, 4'hF, 0, 0, 2'd0, 0, 0, r);
        axi_write(BASE + 32'h24, 32'h7, 4'hF, 1, 0, 2'd1, 0, 0, r);
        check("sc_fail_bresp", r, 2'b00);
        axi_read(BASE + 32'h24, 0, 0, 2'd1, 0, d, r);
        check("sc_fail_rdata", d, 32'h1234);
        axi_write(BASE + 32'h28, 32'h99, 4'hF, 1, 0, 2'd1, 0, 0, r);
        check("sc_noresv_bresp", r, 2'b00);

        // W leads AW by 3 cycles, B backpressured for 4 cycles.
        axi_write(BASE + 32'h34, 32'hCAFEF00D, 4'hF, 0, 0, 2'd1, 3, 4, r);
        axi_read(BASE + 32'h34, 0, 0, 2'd1, 0, d, r);
        check("wlead_rdata", d, 32'hCAFEF00D);

        // Simultaneous AW/W/AR: the read must observe the new data.
        fork
            axi_write(BASE + 32'h38, 32'h0BADCAFE, 4'hF, 0, 0, 2'd1, 0, 0, r);
            axi_read(BASE + 32'h38, 0, 0, 2'd1, 0, d2, r2);
        join
        check("prio_rdata", d2, 32'h0BADCAFE);

        // Errors and range boundaries.
        axi_read(BASE + SPAN, 0, 0, 2'd1, 0, d, r);
        check("oor_rresp", r, 2'b11);
        check("oor_rdata", d, 0);
        axi_read(BASE + 32'h10, 0, 8'd3, 2'd1, 0, d, r);
        check("len_rresp", r, 2'b10);
        axi_read(BASE - 4, 0, 0, 2'd1, 0, d, r);
        check("below_rresp", r, 2'b11);
        axi_read(BASE + 32'h12, 0, 0, 2'd1, 0, d, r);
        check("misalign_rresp", r, 2'b11);
        axi_write(BASE + SPAN, 32'h1, 4'hF, 0, 0, 2'd1, 0, 0, r);
        check("oor_bresp", r, 2'b11);
        axi_write(BASE + 32'h10, 32'h1, 4'hF, 0, 0, 2'd2, 0, 0, r);
        check("burst_bresp", r, 2'b10);
        axi_write(BASE + SPAN - 4, 32'h600DF00D, 4'hF, 0, 0, 2'd1, 0, 0, r);
        axi_read(BASE + SPAN - 4, 0, 0, 2'd1, 0, d, r);
        check("last_word_rdata", d, 32'h600DF00D);

        // Reset while in RD_RESP; memory survives.
        axi_read(BASE + 32'h10, 1, 0, 2'd1, 1, d, r);
        axi_read(BASE + 32'h10, 0, 0, 2'd1, 0, d, r);
        check("post_rst_rdata", d, 32'hDEADBEEF);

        // Randomized traffic over a small word pool plus occasional bad accesses.
        for (int i = 0; i < 8; i++) begin
            axi_write(BASE + 32'h40 + 32'(i * 4), $urandom, 4'hF, 0, 0, 2'd1, 0, 0, r);
        end
        for (int i = 0; i < 150; i++) begin
            logic [7:0] len;
            logic [1:0] burst;
            addr  = BASE + 32'h40 + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 9) == 0) addr = addr + SPAN + 32'($urandom_range(0, 3));
            len   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 15)) : 8'd0;
            burst = ($urandom_range(0, 9) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                axi_read(addr, 1'($urandom), len, burst, 0, d, r);
            end else begin
                axi_write(addr, $urandom, 4'($urandom), 1'($urandom), len, burst,
                          $urandom_range(0, 2), $urandom_range(0, 2), r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
